// File: rtl/crunch_pkg.sv
// crunch_pkg: shared types and constants for the crunch dispatcher slice.
package crunch_pkg;
  localparam int DIGEST_W = 128;
  localparam logic [31:0] MD5_A = 32'h6745_2301;
  localparam logic [31:0] MD5_B = 32'hefcd_ab89;
  localparam logic [31:0] MD5_C = 32'h98ba_dcfe;
  localparam logic [31:0] MD5_D = 32'h1032_5476;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_GO    = 3'd3,
    ST_GUARD = 3'd4,
    ST_WAIT  = 3'd5,
    ST_CHECK = 3'd6
  } unit_st_e;
endpackage

// File: rtl/crunch_unit_fsm.sv
// crunch_unit_fsm: per-cruncher sequencer holding its state and latched candidate ID.
module crunch_unit_fsm
  import crunch_pkg::*;
#(
  parameter int IDW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           accept,
  input  logic           load_gnt,
  input  logic           check_gnt,
  input  logic           done,
  input  logic [IDW-1:0] cand_id,
  output unit_st_e       state,
  output logic [IDW-1:0] id
);
  unit_st_e       state_q, state_d;
  logic [IDW-1:0] id_q, id_d;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE:  if (accept) begin
                  state_d = ST_CLR;
                  id_d    = cand_id;
                end
      ST_CLR:   state_d = ST_LOAD;
      ST_LOAD:  state_d = load_gnt ? ST_GO : ST_LOAD;
      ST_GO:    state_d = ST_GUARD;
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT:  state_d = done ? ST_CHECK : ST_WAIT;
      ST_CHECK: state_d = check_gnt ? ST_IDLE : ST_CHECK;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign state = state_q;
  assign id    = id_q;
endmodule

// File: rtl/crunch_dispatch.sv
// crunch_dispatch: round-robin scheduler of candidates onto NUNITS crunchers with digest match reporting.
// Define MATCH_HALT_EN to stop accepting candidates after the first match.
module crunch_dispatch
  import crunch_pkg::*;
#(
  parameter int NUNITS = 4,
  parameter int IDW    = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cand_valid,
  output logic                       cand_ready,
  input  logic [IDW-1:0]             cand_id,
  input  logic [DIGEST_W-1:0]        target,
  output logic [NUNITS-1:0]          unit_reset,
  output logic [NUNITS-1:0]          msg_we,
  output logic [IDW-1:0]             msg_data,
  output logic [NUNITS-1:0]          unit_start,
  input  logic [NUNITS-1:0]          unit_done,
  input  logic [NUNITS*DIGEST_W-1:0] unit_digest,
  output logic                       match_valid,
  output logic [IDW-1:0]             match_id,
  output logic                       busy
);
  localparam int PW = NUNITS > 1 ? $clog2(NUNITS) : 1;

  logic [1:0]          rs_q, rs_d;
  logic                rst_n_i;
  logic [PW-1:0]       rr_q, rr_d, pick;
  logic                found, hit, halted_q, halted_d;
  logic                match_valid_q, match_valid_d;
  logic [IDW-1:0]      match_id_q, match_id_d, gid;
  logic [DIGEST_W-1:0] gdig;
  logic [NUNITS-1:0]   idle, in_load, in_chk, in_clr, in_go, load_gnt, chk_gnt, accept;
  unit_st_e            st [NUNITS];
  logic [IDW-1:0]      ids [NUNITS];

  // Reset asserts immediately but releases two clocks after reset_n rises.
  assign rs_d    = {rs_q[0], 1'b1};
  assign rst_n_i = rs_q[1];

  for (genvar u = 0; u < NUNITS; u++) begin : g_unit
    crunch_unit_fsm #(.IDW(IDW)) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n_i),
      .accept   (accept[u]),
      .load_gnt (load_gnt[u]),
      .check_gnt(chk_gnt[u]),
      .done     (unit_done[u]),
      .cand_id  (cand_id),
      .state    (st[u]),
      .id       (ids[u])
    );
    assign idle[u]    = st[u] == ST_IDLE;
    assign in_clr[u]  = st[u] == ST_CLR;
    assign in_load[u] = st[u] == ST_LOAD;
    assign in_go[u]   = st[u] == ST_GO;
    assign in_chk[u]  = st[u] == ST_CHECK;
  end

  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUNITS; k++) begin
      idx = (int'(rr_q) + k) % NUNITS;
      if (!found && idle[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // Shared message bus and result port: lowest index wins, others hold.
  always_comb begin
    logic lf, cf;
    lf       = 1'b0;
    cf       = 1'b0;
    load_gnt = '0;
    chk_gnt  = '0;
    msg_data = '0;
    gdig     = '0;
    gid      = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (!lf && in_load[i]) begin
        lf          = 1'b1;
        load_gnt[i] = 1'b1;
        msg_data    = ids[i];
      end
      if (!cf && in_chk[i]) begin
        cf         = 1'b1;
        chk_gnt[i] = 1'b1;
        gdig       = unit_digest[i*DIGEST_W +: DIGEST_W];
        gid        = ids[i];
      end
    end
  end

  always_comb begin
    cand_ready    = rst_n_i && found && !halted_q;
    accept        = (cand_valid && cand_ready) ? NUNITS'(1) << pick : '0;
    rr_d          = !(cand_valid && cand_ready) ? rr_q
                  : (int'(pick) == NUNITS - 1) ? '0 : pick + PW'(1);
    hit           = |chk_gnt && gdig == target;
    match_valid_d = hit;
    match_id_d    = hit ? gid : '0;
`ifdef MATCH_HALT_EN
    halted_d      = halted_q || hit;
`else
    halted_d      = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rs_q <= '0;
    else          rs_q <= rs_d;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q          <= '0;
      halted_q      <= 1'b0;
      match_valid_q <= 1'b0;
      match_id_q    <= '0;
    end else begin
      rr_q          <= rr_d;
      halted_q      <= halted_d;
      match_valid_q <= match_valid_d;
      match_id_q    <= match_id_d;
    end
  end

  assign unit_reset  = in_clr;
  assign msg_we      = load_gnt;
  assign unit_start  = in_go;
  assign match_valid = match_valid_q;
  assign match_id    = match_id_q;
  assign busy        = ~&idle;
endmodule
